// File: rtl/iommu_lspa_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | iommu_lspa_pkg : shared op encoding, memory-port structs, id helpers        |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
package iommu_lspa_pkg;

  typedef enum logic [1:0] {
    LS_LOAD  = 2'd0,
    LS_STORE = 2'd1,
    LS_AMO   = 2'd2
  } ls_op_e;

  localparam int unsigned c_LSPA_ADDR_W = 46;
  localparam int unsigned c_LSPA_DATA_W = 512;
  localparam int unsigned c_LSPA_SIZE_W = 7;
  localparam int unsigned c_LSPA_ID_W   = 4;

  // Memory-side views for the default four-requestor configuration.
  typedef struct packed {
    logic [c_LSPA_ADDR_W-1:0] addr;
    ls_op_e                   op;
    logic [c_LSPA_SIZE_W-1:0] size;
    logic [c_LSPA_ID_W-1:0]   id;
  } lspa_mem_req_t;

  typedef struct packed {
    logic [c_LSPA_DATA_W-1:0] data;
    logic                     acc_fault;
    logic                     poison;
    logic [c_LSPA_ID_W-1:0]   id;
  } lspa_mem_rsp_t;

  function automatic int unsigned lspa_id_idx(input int unsigned id, input int unsigned tag_w);
    return id >> tag_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_iommu_rr_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rv_iommu_rr_arb : round-robin arbiter, priority starts after last grant     |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module rv_iommu_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  logic [IDX_W-1:0] last_q;
  logic             w_found;
  int unsigned      w_cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    w_found   = 1'b0;
    w_cand    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = (32'(last_q) + k) % NUM_REQ;
      if (!w_found && req_i[w_cand]) begin
        w_found       = 1'b1;
        gnt_o[w_cand] = 1'b1;
        gnt_idx_o     = IDX_W'(w_cand);
      end
    end
  end

  // Reset to the last index so requestor 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else if (advance_i) begin
      last_q <= gnt_idx_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv_iommu_lspa_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rv_iommu_lspa_arb : N-channel load/store port arbiter with credit limit     |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module rv_iommu_lspa_arb
  import iommu_lspa_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = 46,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned TAG_W     = 2,
  parameter int unsigned SIZE_W    = 7,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ*ADDR_W-1:0]         req_addr_i,
  input  logic [NUM_REQ*2-1:0]              req_op_i,
  input  logic [NUM_REQ*TAG_W-1:0]          req_tag_i,
  input  logic [NUM_REQ*SIZE_W-1:0]         req_size_i,
  input  logic [NUM_REQ-1:0]                req_irdy_i,
  output logic [NUM_REQ-1:0]                req_trdy_o,
  output logic [ADDR_W-1:0]                 mem_req_addr_o,
  output logic [1:0]                        mem_req_op_o,
  output logic [SIZE_W-1:0]                 mem_req_size_o,
  output logic [IDX_W+TAG_W-1:0]            mem_req_id_o,
  output logic                              mem_req_irdy_o,
  input  logic                              mem_req_trdy_i,
  input  logic [DATA_W-1:0]                 mem_rsp_data_i,
  input  logic                              mem_rsp_acc_fault_i,
  input  logic                              mem_rsp_poison_i,
  input  logic [IDX_W+TAG_W-1:0]            mem_rsp_id_i,
  input  logic                              mem_rsp_irdy_i,
  output logic                              mem_rsp_trdy_o,
  output logic [DATA_W-1:0]                 rsp_data_o,
  output logic                              rsp_acc_fault_o,
  output logic                              rsp_poison_o,
  output logic [TAG_W-1:0]                  rsp_tag_o,
  output logic [NUM_REQ-1:0]                rsp_irdy_o,
  input  logic [NUM_REQ-1:0]                rsp_trdy_i,
  output logic                              rsp_id_err_o,
  output logic [$clog2(MAX_OUTST+1)-1:0]    outst_cnt_o
);

  localparam int unsigned        c_CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_OUTST);

  logic [ADDR_W-1:0]      addr_q,  addr_d;
  logic [1:0]             op_q,    op_d;
  logic [SIZE_W-1:0]      size_q,  size_d;
  logic [IDX_W+TAG_W-1:0] id_q,    id_d;
  logic                   irdy_q,  irdy_d;
  logic [c_CNT_W-1:0]     outst_q, outst_d;
  logic                   err_q,   err_d;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_stage_free;
  logic               w_xfer;
  logic               w_full;
  logic               w_inc;
  logic               w_dec;
  logic               w_bad_id;
  int unsigned        w_rsp_idx;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [1:0]         w_sel_op;
  logic [TAG_W-1:0]   w_sel_tag;
  logic [SIZE_W-1:0]  w_sel_size;

  // Credit check uses the registered count only; a same-cycle response does not free a slot.
  assign w_full = (outst_q >= c_MAX);

  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req_irdy_i[i] && ((req_op_i[i*2 +: 2] == LS_STORE) || !w_full);
    end
  end

  rv_iommu_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (w_elig),
    .advance_i (w_xfer),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx)
  );

  assign w_stage_free = !irdy_q || mem_req_trdy_i;
  assign req_trdy_o   = w_gnt & {NUM_REQ{w_stage_free}};
  assign w_xfer       = |req_trdy_o;

  always_comb begin
    w_sel_addr = '0;
    w_sel_op   = '0;
    w_sel_tag  = '0;
    w_sel_size = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
        w_sel_op   = req_op_i[i*2 +: 2];
        w_sel_tag  = req_tag_i[i*TAG_W +: TAG_W];
        w_sel_size = req_size_i[i*SIZE_W +: SIZE_W];
      end
    end
  end

  always_comb begin
    addr_d = addr_q;
    op_d   = op_q;
    size_d = size_q;
    id_d   = id_q;
    irdy_d = irdy_q;
    if (w_xfer) begin
      addr_d = w_sel_addr;
      op_d   = w_sel_op;
      size_d = w_sel_size;
      id_d   = {w_gnt_idx, w_sel_tag};
      irdy_d = 1'b1;
    end else if (mem_req_trdy_i) begin
      irdy_d = 1'b0;
    end
  end

  // Out-of-range indices are swallowed here so a bad id can never wedge the port.
  always_comb begin
    w_rsp_idx      = lspa_id_idx(32'(mem_rsp_id_i), TAG_W);
    w_bad_id       = (w_rsp_idx >= NUM_REQ);
    rsp_irdy_o     = '0;
    mem_rsp_trdy_o = w_bad_id;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_rsp_idx == i) begin
        rsp_irdy_o[i]  = mem_rsp_irdy_i;
        mem_rsp_trdy_o = rsp_trdy_i[i];
      end
    end
  end

  assign w_inc = w_xfer && (w_sel_op != LS_STORE);
  assign w_dec = mem_rsp_irdy_i && mem_rsp_trdy_o;

  always_comb begin
    outst_d = outst_q;
    if (w_inc && !w_dec) begin
      outst_d = outst_q + 1'b1;
    end else if (w_dec && !w_inc && (outst_q != '0)) begin
      outst_d = outst_q - 1'b1;
    end
  end

  assign err_d = mem_rsp_irdy_i && w_bad_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      op_q    <= '0;
      size_q  <= '0;
      id_q    <= '0;
      irdy_q  <= 1'b0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      op_q    <= op_d;
      size_q  <= size_d;
      id_q    <= id_d;
      irdy_q  <= irdy_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_addr_o  = addr_q;
  assign mem_req_op_o    = op_q;
  assign mem_req_size_o  = size_q;
  assign mem_req_id_o    = id_q;
  assign mem_req_irdy_o  = irdy_q;
  assign outst_cnt_o     = outst_q;
  assign rsp_id_err_o    = err_q;
  assign rsp_data_o      = mem_rsp_data_i;
  assign rsp_acc_fault_o = mem_rsp_acc_fault_i;
  assign rsp_poison_o    = mem_rsp_poison_i;
  assign rsp_tag_o       = mem_rsp_id_i[TAG_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_rv_iommu_lspa_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_rv_iommu_lspa_arb : directed self-checking bench for the LSPA arbiter    |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_rv_iommu_lspa_arb;
  import iommu_lspa_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Four-requestor instance
  logic [4*46-1:0] req_addr;
  logic [7:0]      req_op;
  logic [7:0]      req_tag;
  logic [27:0]     req_size;
  logic [3:0]      req_irdy, req_trdy;
  logic [45:0]     mem_req_addr;
  logic [1:0]      mem_req_op;
  logic [6:0]      mem_req_size;
  logic [3:0]      mem_req_id;
  logic            mem_req_irdy, mem_req_trdy;
  logic [511:0]    mem_rsp_data;
  logic            mem_rsp_fault, mem_rsp_poison;
  logic [3:0]      mem_rsp_id;
  logic            mem_rsp_irdy, mem_rsp_trdy;
  logic [511:0]    rsp_data;
  logic            rsp_fault, rsp_poison;
  logic [1:0]      rsp_tag;
  logic [3:0]      rsp_irdy, rsp_trdy;
  logic            id_err;
  logic [2:0]      outst;

  // Three-requestor instance, used for the out-of-range id case
  logic [3*46-1:0] req_addr3;
  logic [5:0]      req_op3;
  logic [5:0]      req_tag3;
  logic [20:0]     req_size3;
  logic [2:0]      req_irdy3, req_trdy3;
  logic [45:0]     mem_req_addr3;
  logic [1:0]      mem_req_op3;
  logic [6:0]      mem_req_size3;
  logic [3:0]      mem_req_id3;
  logic            mem_req_irdy3, mem_req_trdy3;
  logic [511:0]    mem_rsp_data3;
  logic [3:0]      mem_rsp_id3;
  logic            mem_rsp_irdy3, mem_rsp_trdy3;
  logic [511:0]    rsp_data3;
  logic            rsp_fault3, rsp_poison3;
  logic [1:0]      rsp_tag3;
  logic [2:0]      rsp_irdy3, rsp_trdy3;
  logic            id_err3;
  logic [2:0]      outst3;

  rv_iommu_lspa_arb #(.NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr_i(req_addr), .req_op_i(req_op), .req_tag_i(req_tag), .req_size_i(req_size),
    .req_irdy_i(req_irdy), .req_trdy_o(req_trdy),
    .mem_req_addr_o(mem_req_addr), .mem_req_op_o(mem_req_op), .mem_req_size_o(mem_req_size),
    .mem_req_id_o(mem_req_id), .mem_req_irdy_o(mem_req_irdy), .mem_req_trdy_i(mem_req_trdy),
    .mem_rsp_data_i(mem_rsp_data), .mem_rsp_acc_fault_i(mem_rsp_fault),
    .mem_rsp_poison_i(mem_rsp_poison), .mem_rsp_id_i(mem_rsp_id),
    .mem_rsp_irdy_i(mem_rsp_irdy), .mem_rsp_trdy_o(mem_rsp_trdy),
    .rsp_data_o(rsp_data), .rsp_acc_fault_o(rsp_fault), .rsp_poison_o(rsp_poison),
    .rsp_tag_o(rsp_tag), .rsp_irdy_o(rsp_irdy), .rsp_trdy_i(rsp_trdy),
    .rsp_id_err_o(id_err), .outst_cnt_o(outst)
  );

  rv_iommu_lspa_arb #(.NUM_REQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_addr_i(req_addr3), .req_op_i(req_op3), .req_tag_i(req_tag3), .req_size_i(req_size3),
    .req_irdy_i(req_irdy3), .req_trdy_o(req_trdy3),
    .mem_req_addr_o(mem_req_addr3), .mem_req_op_o(mem_req_op3), .mem_req_size_o(mem_req_size3),
    .mem_req_id_o(mem_req_id3), .mem_req_irdy_o(mem_req_irdy3), .mem_req_trdy_i(mem_req_trdy3),
    .mem_rsp_data_i(mem_rsp_data3), .mem_rsp_acc_fault_i(1'b0),
    .mem_rsp_poison_i(1'b0), .mem_rsp_id_i(mem_rsp_id3),
    .mem_rsp_irdy_i(mem_rsp_irdy3), .mem_rsp_trdy_o(mem_rsp_trdy3),
    .rsp_data_o(rsp_data3), .rsp_acc_fault_o(rsp_fault3), .rsp_poison_o(rsp_poison3),
    .rsp_tag_o(rsp_tag3), .rsp_irdy_o(rsp_irdy3), .rsp_trdy_i(rsp_trdy3),
    .rsp_id_err_o(id_err3), .outst_cnt_o(outst3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op,
                         input logic [45:0] addr, input logic [1:0] tag);
    req_irdy[i]          = v;
    req_op[i*2 +: 2]     = op;
    req_addr[i*46 +: 46] = addr;
    req_tag[i*2 +: 2]    = tag;
    req_size[i*7 +: 7]   = 7'd8;
  endtask

  initial begin
    rst_n = 1'b0;
    req_addr = '0; req_op = '0; req_tag = '0; req_size = '0; req_irdy = '0;
    mem_req_trdy = 1'b1; mem_rsp_data = '0; mem_rsp_fault = 1'b0; mem_rsp_poison = 1'b0;
    mem_rsp_id = '0; mem_rsp_irdy = 1'b0; rsp_trdy = 4'hF;
    req_addr3 = '0; req_op3 = '0; req_tag3 = '0; req_size3 = '0; req_irdy3 = '0;
    mem_req_trdy3 = 1'b1; mem_rsp_data3 = '0; mem_rsp_id3 = '0; mem_rsp_irdy3 = 1'b0;
    rsp_trdy3 = 3'b111;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_mem_irdy", 64'(mem_req_irdy), 64'd0);
    check_eq("rst_mem_addr", 64'(mem_req_addr), 64'd0);
    check_eq("rst_outst",    64'(outst),        64'd0);
    check_eq("rst_id_err",   64'(id_err),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single load from requestor 0
    @(negedge clk);
    set_req(0, 1'b1, LS_LOAD, 46'h1000, 2'd1);
    #1;
    check_eq("ld_trdy", 64'(req_trdy), 64'b0001);
    @(negedge clk);
    set_req(0, 1'b0, LS_LOAD, 46'h0, 2'd0);
    #1;
    check_eq("ld_mem_irdy", 64'(mem_req_irdy), 64'd1);
    check_eq("ld_mem_addr", 64'(mem_req_addr), 64'h1000);
    check_eq("ld_mem_id",   64'(mem_req_id),   64'd1);
    check_eq("ld_mem_op",   64'(mem_req_op),   64'd0);
    check_eq("ld_outst",    64'(outst),        64'd1);
    @(negedge clk);
    #1;
    check_eq("ld_mem_drain", 64'(mem_req_irdy), 64'd0);
    mem_rsp_data = 512'h2001; mem_rsp_id = 4'b0001; mem_rsp_irdy = 1'b1;
    #1;
    check_eq("ld_rsp_irdy", 64'(rsp_irdy),      64'b0001);
    check_eq("ld_rsp_tag",  64'(rsp_tag),       64'd1);
    check_eq("ld_rsp_data", rsp_data[63:0],     64'h2001);
    check_eq("ld_rsp_trdy", 64'(mem_rsp_trdy),  64'd1);
    @(negedge clk);
    mem_rsp_irdy = 1'b0;
    #1;
    check_eq("ld_outst_back", 64'(outst), 64'd0);

    // Fairness: last grant was 0, so order continues 1,2,3,0,...
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, LS_STORE, 46'(32'h2000 + i * 64), 2'd0);
    for (int k = 0; k < 8; k++) begin
      #1;
      check_eq("rr_gnt", 64'(req_trdy), 64'(1 << ((k + 1) % 4)));
      if (k > 0) check_eq("rr_mem_id", 64'(mem_req_id), 64'((k % 4) * 4));
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, LS_STORE, 46'h0, 2'd0);
    #1;
    check_eq("rr_last_id",  64'(mem_req_id),   64'd0);
    check_eq("rr_last_vld", 64'(mem_req_irdy), 64'd1);

    // Credit limit
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1'b1, LS_LOAD, 46'(32'h3000 + k * 64), 2'(k));
      #1;
      check_eq("cr_ld_trdy", 64'(req_trdy), 64'b0010);
      @(negedge clk);
    end
    set_req(1, 1'b1, LS_LOAD, 46'h3400, 2'd0);
    set_req(2, 1'b1, LS_STORE, 46'h4000, 2'd0);
    #1;
    check_eq("cr_full",      64'(outst),    64'd4);
    check_eq("cr_store_gnt", 64'(req_trdy), 64'b0100);
    @(negedge clk);
    set_req(2, 1'b0, LS_STORE, 46'h0, 2'd0);
    mem_rsp_id = 4'b0100; mem_rsp_irdy = 1'b1;
    #1;
    check_eq("cr_no_bypass", 64'(req_trdy), 64'd0);
    check_eq("cr_still4",    64'(outst),    64'd4);
    @(negedge clk);
    mem_rsp_irdy = 1'b0;
    #1;
    check_eq("cr_outst3", 64'(outst),    64'd3);
    check_eq("cr_ld_ok",  64'(req_trdy), 64'b0010);
    @(negedge clk);
    set_req(1, 1'b0, LS_LOAD, 46'h0, 2'd0);
    #1;
    check_eq("cr_refill", 64'(outst), 64'd4);
    for (int k = 0; k < 4; k++) begin
      mem_rsp_id = 4'(4 + k); mem_rsp_irdy = 1'b1;
      @(negedge clk);
    end
    mem_rsp_irdy = 1'b0;
    #1;
    check_eq("cr_drained", 64'(outst), 64'd0);

    // Backpressure on the request and response sides
    @(negedge clk);
    mem_req_trdy = 1'b0;
    set_req(3, 1'b1, LS_LOAD, 46'hABC0, 2'd2);
    #1;
    check_eq("bp_accept", 64'(req_trdy), 64'b1000);
    @(negedge clk);
    set_req(3, 1'b1, LS_LOAD, 46'hDEF0, 2'd1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("bp_no_trdy", 64'(req_trdy),     64'd0);
      check_eq("bp_addr",    64'(mem_req_addr), 64'hABC0);
      check_eq("bp_id",      64'(mem_req_id),   64'd14);
      check_eq("bp_vld",     64'(mem_req_irdy), 64'd1);
      @(negedge clk);
    end
    mem_req_trdy = 1'b1;
    #1;
    check_eq("bp_release", 64'(req_trdy), 64'b1000);
    @(negedge clk);
    set_req(3, 1'b0, LS_LOAD, 46'h0, 2'd0);
    #1;
    check_eq("bp_next_addr", 64'(mem_req_addr), 64'hDEF0);
    check_eq("bp_next_id",   64'(mem_req_id),   64'd13);
    check_eq("bp_outst",     64'(outst),        64'd2);
    @(negedge clk);
    mem_rsp_id = 4'b1001; mem_rsp_irdy = 1'b1; rsp_trdy = 4'b1011;
    #1;
    check_eq("bp_rsp_hold",  64'(mem_rsp_trdy), 64'd0);
    check_eq("bp_rsp_irdy",  64'(rsp_irdy),     64'b0100);
    @(negedge clk);
    #1;
    check_eq("bp_rsp_hold2", 64'(mem_rsp_trdy), 64'd0);
    check_eq("bp_rsp_cnt",   64'(outst),        64'd2);
    rsp_trdy = 4'hF;
    #1;
    check_eq("bp_rsp_go", 64'(mem_rsp_trdy), 64'd1);
    @(negedge clk);
    mem_rsp_irdy = 1'b0;
    #1;
    check_eq("bp_rsp_dec", 64'(outst), 64'd1);

    // Reset in the middle of traffic
    @(negedge clk);
    mem_req_trdy = 1'b0;
    set_req(2, 1'b1, LS_LOAD, 46'h5000, 2'd0);
    #1;
    check_eq("mr_gnt", 64'(req_trdy), 64'b0100);
    @(negedge clk);
    set_req(2, 1'b0, LS_LOAD, 46'h0, 2'd0);
    #1;
    check_eq("mr_outst2",  64'(outst),        64'd2);
    check_eq("mr_pending", 64'(mem_req_irdy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_irdy", 64'(mem_req_irdy), 64'd0);
    check_eq("mr_cnt",  64'(outst),        64'd0);
    check_eq("mr_addr", 64'(mem_req_addr), 64'd0);
    check_eq("mr_id",   64'(mem_req_id),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_req_trdy = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, LS_STORE, 46'h6000, 2'd0);
    #1;
    check_eq("mr_first_gnt", 64'(req_trdy), 64'b0001);
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, LS_STORE, 46'h0, 2'd0);

    // Out-of-range response index on the three-requestor instance
    @(negedge clk);
    req_irdy3[0] = 1'b1; req_op3[1:0] = LS_LOAD; req_addr3[45:0] = 46'h7000; req_tag3[1:0] = 2'd1;
    #1;
    check_eq("bad_ld_trdy", 64'(req_trdy3), 64'b001);
    @(negedge clk);
    req_irdy3 = '0;
    #1;
    check_eq("bad_outst1", 64'(outst3),  64'd1);
    check_eq("bad_err_lo", 64'(id_err3), 64'd0);
    mem_rsp_id3 = 4'b1101; mem_rsp_irdy3 = 1'b1; rsp_trdy3 = 3'b000;
    #1;
    check_eq("bad_trdy", 64'(mem_rsp_trdy3), 64'd1);
    check_eq("bad_irdy", 64'(rsp_irdy3),     64'd0);
    @(negedge clk);
    mem_rsp_irdy3 = 1'b0;
    #1;
    check_eq("bad_err_pulse", 64'(id_err3), 64'd1);
    check_eq("bad_dec",       64'(outst3),  64'd0);
    @(negedge clk);
    #1;
    check_eq("bad_err_clear", 64'(id_err3), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_iommu_lspa_arb.md
Name: rv_iommu_lspa_arb

Overview:
- Parametrised N-channel load/store port arbiter for the IOMMU. It multiplexes page-table walker, command-queue, fault-queue and MSI-table requestors onto one memory port.
- Arbitration is round-robin with a registered output stage and a bounded count of outstanding loads/AMOs.
- Load/AMO responses return tagged with {requestor index, tag} and are routed back to the issuing requestor.
- Successor to the single-walker stub port; sits between the IOMMU clients and the system interconnect.

Parameters:
- NUM_REQ, 4, number of requestor channels (≥2).
- ADDR_W, 46, physical address width.
- DATA_W, 512, load/AMO data width.
- TAG_W, 2, per-requestor transaction tag width.
- SIZE_W, 7, access size field width (bytes).
- MAX_OUTST, 4, maximum loads/AMOs awaiting a response (≥1).
- IDX_W, $clog2(NUM_REQ), requestor index width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_addr_i  in  NUM_REQ*ADDR_W  per-requestor address
- req_op_i  in  NUM_REQ*2  per-requestor op (LS_LOAD / LS_STORE / LS_AMO)
- req_tag_i  in  NUM_REQ*TAG_W  per-requestor tag
- req_size_i  in  NUM_REQ*SIZE_W  per-requestor size
- req_irdy_i  in  NUM_REQ  request valid
- req_trdy_o  out  NUM_REQ  request accepted
- mem_req_addr_o  out  ADDR_W  memory request address
- mem_req_op_o  out  2  memory request op
- mem_req_size_o  out  SIZE_W  memory request size
- mem_req_id_o  out  IDX_W+TAG_W  {index, tag}
- mem_req_irdy_o  out  1  memory request valid
- mem_req_trdy_i  in  1  memory request accepted
- mem_rsp_data_i  in  DATA_W  response data
- mem_rsp_acc_fault_i  in  1  access fault
- mem_rsp_poison_i  in  1  poisoned data
- mem_rsp_id_i  in  IDX_W+TAG_W  response id
- mem_rsp_irdy_i  in  1  response valid
- mem_rsp_trdy_o  out  1  response accepted
- rsp_data_o  out  DATA_W  broadcast response data
- rsp_acc_fault_o  out  1  broadcast fault
- rsp_poison_o  out  1  broadcast poison
- rsp_tag_o  out  TAG_W  broadcast tag
- rsp_irdy_o  out  NUM_REQ  one-hot response valid
- rsp_trdy_i  in  NUM_REQ  per-requestor response ready
- rsp_id_err_o  out  1  one-cycle pulse: response id index ≥ NUM_REQ
- outst_cnt_o  out  $clog2(MAX_OUTST+1)  outstanding load/AMO count

Behaviour:
- Handshake: a transfer occurs in the cycle where irdy and trdy are both high. irdy must not drop, and payload must stay stable, until transfer.
- Eligibility: requestor i is eligible if req_irdy_i[i] && (op==LS_STORE || outst_cnt < MAX_OUTST). The count is checked without bypass from a same-cycle response.
- Grant: round-robin starting at last_grant+1, wrapping at NUM_REQ-1 → 0. At most one req_trdy_o bit is high.
- req_trdy_o[i] is high only when i is granted and the output stage is empty or mem_req_trdy_i is high.
- last_grant updates only on a request transfer.
- Output stage: one-entry register. A request accepted in cycle N appears on mem_req_* in cycle N+1 and holds until mem_req_trdy_i. Back-to-back throughput is 1/cycle.
- mem_req_id_o = {granted index, req tag}.
- Outstanding count:
  - +1 on requestor transfer of a LOAD/AMO.
  - −1 on a mem_rsp transfer.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTST. STORE never counts and produces no response.
- Response routing: combinational, zero latency.
  - idx = mem_rsp_id_i[IDX_W+TAG_W-1:TAG_W].
  - rsp_irdy_o = one-hot(idx) & {NUM_REQ{mem_rsp_irdy_i}}.
  - mem_rsp_trdy_o = rsp_trdy_i[idx].
  - rsp_* data, fault, poison and tag are broadcast.
- Bad id (idx ≥ NUM_REQ): mem_rsp_trdy_o = 1, the response is dropped, rsp_id_err_o pulses for one cycle, and the count still decrements.
- Reset values: mem_req_irdy_o=0, all payload regs 0, last_grant=NUM_REQ-1 (so requestor 0 has first priority), outst_cnt=0, rsp_id_err_o=0. Reset mid-transaction discards in-flight state; no replay.

Decomposition:
- Package iommu_lspa_pkg holds:
  - ls_op_e: LS_LOAD=2'd0, LS_STORE=2'd1, LS_AMO=2'd2.
  - the mem request/response struct typedefs.
  - a helper function for id packing.
- One sub-module, rv_iommu_rr_arb: parametrised round-robin arbiter with inputs req[NUM_REQ] and advance, outputs one-hot gnt and gnt_idx.

Test Plan:
- Single load: req0 LOAD addr 0x1000 tag 1 → mem_req next cycle with id {0,1}. Response data 0x2001 id {0,1} → rsp_irdy_o=0001, rsp_tag_o=1, outst_cnt back to 0.
- Fairness: all 4 requestors hold STORE continuously with mem_req_trdy_i=1 → grant order 0,1,2,3,0,… with exactly one transfer per cycle.
- Credit limit: MAX_OUTST=4, issue 4 LOADs without responses → outst_cnt=4. A 5th LOAD is stalled while a concurrent STORE from another requestor is still granted. One response → the LOAD is accepted the following cycle.
- Backpressure: mem_req_trdy_i=0 for 5 cycles → mem_req_* stable and no req_trdy_o. Response with rsp_trdy_i[2]=0 → mem_rsp_trdy_o=0 until it rises.
- Bad id: NUM_REQ=3, response id index 3 → mem_rsp_trdy_o=1, rsp_irdy_o=0, rsp_id_err_o pulses 1 cycle, count decrements.
- Reset mid-op: assert rst_n=0 with 2 outstanding loads and a pending mem_req → all outputs return to reset values immediately, and requestor 0 gets the first grant after release.
